// File: rtl/modport_accel.sv
// Streaming lane-wise dot-product accelerator: two valid/ready operand streams,
// K_WORDS multiply-accumulates per job, one saturated packed result pulse.
module modport_accel #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_BW     = 64,
    parameter int K_WORDS    = 16,
    parameter int OUT_SHIFT  = 0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [MEM_BW-1:0] activations_input,
    input  logic              activations_valid,
    output logic              activations_ready,
    input  logic [MEM_BW-1:0] weights_input,
    input  logic              weights_valid,
    output logic              weights_ready,
    output logic [MEM_BW-1:0] output_data,
    output logic              output_valid,
    input  logic              start,
    output logic              running
);

    localparam int LANES = MEM_BW / DATA_WIDTH;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W = PROD_W + $clog2(K_WORDS) + 1;
    localparam int CNT_W = $clog2(K_WORDS + 1);
    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K_WORDS);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [MEM_BW-1:0]        r_act_data;
    logic [MEM_BW-1:0]        r_wgt_data;
    logic                     r_act_full;
    logic                     r_wgt_full;
    logic                     r_act_ready;
    logic                     r_wgt_ready;
    logic [CNT_W-1:0]         r_act_cnt;
    logic [CNT_W-1:0]         r_wgt_cnt;
    logic [CNT_W-1:0]         r_mac_cnt;
    logic signed [ACC_W-1:0]  r_acc [LANES];
    logic [MEM_BW-1:0]        r_out_data;
    logic                     r_out_valid;
    logic                     r_running;

    logic                     w_act_xfer;
    logic                     w_wgt_xfer;
    logic                     w_mac;
    logic signed [PROD_W-1:0] w_ext_a [LANES];
    logic signed [PROD_W-1:0] w_ext_b [LANES];
    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [ACC_W-1:0]  w_acc_next [LANES];
    logic [MEM_BW-1:0]        w_out_data;

    // Scale one accumulator and clamp it into the signed lane range.
    function automatic logic [DATA_WIDTH-1:0] sat_lane(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] sh;
        logic [DATA_WIDTH-1:0]   r;
        sh = v >>> OUT_SHIFT;
        if (sh > SAT_MAX) begin
            r = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sh < SAT_MIN) begin
            r = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            r = sh[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    // Handshake/MAC qualifiers, lane products, next accumulators and packed result.
    always_comb begin
        w_act_xfer = 1'b0;
        w_wgt_xfer = 1'b0;
        w_mac      = 1'b0;
        w_out_data = '0;
        if (r_state == ST_RUN) begin
            w_act_xfer = activations_valid && r_act_ready;
            w_wgt_xfer = weights_valid && r_wgt_ready;
            w_mac      = r_act_full && r_wgt_full;
        end else begin
            w_act_xfer = 1'b0;
            w_wgt_xfer = 1'b0;
            w_mac      = 1'b0;
        end
        for (int i = 0; i < LANES; i++) begin
            w_ext_a[i] = {{DATA_WIDTH{r_act_data[i*DATA_WIDTH+DATA_WIDTH-1]}}, r_act_data[i*DATA_WIDTH +: DATA_WIDTH]};
            w_ext_b[i] = {{DATA_WIDTH{r_wgt_data[i*DATA_WIDTH+DATA_WIDTH-1]}}, r_wgt_data[i*DATA_WIDTH +: DATA_WIDTH]};
            w_prod[i] = w_ext_a[i] * w_ext_b[i];
            w_acc_next[i] = r_acc[i] + {{(ACC_W-PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
            w_out_data[i*DATA_WIDTH +: DATA_WIDTH] = sat_lane(w_acc_next[i]);
        end
    end

    // Job FSM with operand registers, stream counters, accumulators and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= ST_IDLE;
            r_act_data  <= '0;
            r_wgt_data  <= '0;
            r_act_full  <= 1'b0;
            r_wgt_full  <= 1'b0;
            r_act_ready <= 1'b0;
            r_wgt_ready <= 1'b0;
            r_act_cnt   <= '0;
            r_wgt_cnt   <= '0;
            r_mac_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_running   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_running   <= 1'b1;
                        r_act_full  <= 1'b0;
                        r_wgt_full  <= 1'b0;
                        r_act_ready <= 1'b1;
                        r_wgt_ready <= 1'b1;
                        r_act_cnt   <= '0;
                        r_wgt_cnt   <= '0;
                        r_mac_cnt   <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            r_acc[i] <= '0;
                        end
                    end else begin
                        r_running   <= 1'b0;
                        r_act_ready <= 1'b0;
                        r_wgt_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A stream's register is never filled and drained on the same edge.
                    if (w_act_xfer) begin
                        r_act_data  <= activations_input;
                        r_act_full  <= 1'b1;
                        r_act_cnt   <= r_act_cnt + CNT_ONE;
                        r_act_ready <= 1'b0;
                    end else if (w_mac) begin
                        r_act_full  <= 1'b0;
                        r_act_ready <= (r_act_cnt < K_CNT);
                    end else begin
                        r_act_full  <= r_act_full;
                        r_act_ready <= r_act_ready;
                    end
                    if (w_wgt_xfer) begin
                        r_wgt_data  <= weights_input;
                        r_wgt_full  <= 1'b1;
                        r_wgt_cnt   <= r_wgt_cnt + CNT_ONE;
                        r_wgt_ready <= 1'b0;
                    end else if (w_mac) begin
                        r_wgt_full  <= 1'b0;
                        r_wgt_ready <= (r_wgt_cnt < K_CNT);
                    end else begin
                        r_wgt_full  <= r_wgt_full;
                        r_wgt_ready <= r_wgt_ready;
                    end
                    if (w_mac) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_acc[i] <= w_acc_next[i];
                        end
                        r_mac_cnt <= r_mac_cnt + CNT_ONE;
                        if (r_mac_cnt == K_LAST) begin
                            r_state     <= ST_OUT;
                            r_out_data  <= w_out_data;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= ST_RUN;
                            r_out_valid <= 1'b0;
                        end
                    end else begin
                        r_state     <= ST_RUN;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_OUT: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_running   <= 1'b0;
                    r_act_ready <= 1'b0;
                    r_wgt_ready <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_running   <= 1'b0;
                    r_act_ready <= 1'b0;
                    r_wgt_ready <= 1'b0;
                    r_act_full  <= 1'b0;
                    r_wgt_full  <= 1'b0;
                end
            endcase
        end
    end

    assign activations_ready = r_act_ready;
    assign weights_ready     = r_wgt_ready;
    assign output_data       = r_out_data;
    assign output_valid      = r_out_valid;
    assign running           = r_running;

endmodule

// File: tb/tb_modport_accel.sv
// Self-checking bench for modport_accel (K_WORDS=4): vector table, skew/backpressure,
// abort, and randomized jobs against a plain-arithmetic dot-product model.
module tb_modport_accel;

    localparam int DW = 8;
    localparam int BW = 64;
    localparam int K = 4;
    localparam int SHIFT = 0;
    localparam int NL = BW / DW;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          start = 1'b0;
    logic          av = 1'b0;
    logic          wv = 1'b0;
    logic [BW-1:0] ad = '0;
    logic [BW-1:0] wd = '0;
    logic          a_rdy;
    logic          w_rdy;
    logic          ov;
    logic          running;
    logic [BW-1:0] od;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] job_act [6];
    logic [BW-1:0] job_wgt [6];

    typedef struct {
        string         name;
        logic [BW-1:0] act;
        logic [BW-1:0] wgt;
        logic [BW-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    modport_accel #(
        .DATA_WIDTH(DW),
        .MEM_BW    (BW),
        .K_WORDS   (K),
        .OUT_SHIFT (SHIFT)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .activations_input(ad),
        .activations_valid(av),
        .activations_ready(a_rdy),
        .weights_input    (wd),
        .weights_valid    (wv),
        .weights_ready    (w_rdy),
        .output_data      (od),
        .output_valid     (ov),
        .start            (start),
        .running          (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    // Dot product of the first K words of each stream, scaled and clamped per lane.
    function automatic logic [BW-1:0] ref_result();
        logic [BW-1:0] r;
        int s;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            s = 0;
            for (int k = 0; k < K; k++) begin
                s += int'($signed(job_act[k][l*DW +: DW])) * int'($signed(job_wgt[k][l*DW +: DW]));
            end
            s = s >>> SHIFT;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            r[l*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    task automatic run_job(input string name, input int gap_pct, input int wgt_delay,
                           input bit poke_start, input bit do_abort, input logic [BW-1:0] exp);
        int a_acc = 0;
        int w_acc = 0;
        int pulses = 0;
        int cyc = 0;
        int pulse_cyc = -1;
        bit a_prev = 1'b0;
        bit w_prev = 1'b0;
        bit done = 1'b0;
        logic [BW-1:0] got = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!done) begin
            ad = job_act[(a_acc < 5) ? a_acc : 5];
            wd = job_wgt[(w_acc < 5) ? w_acc : 5];
            av = (int'($urandom_range(99)) >= gap_pct);
            wv = (cyc >= wgt_delay) && (int'($urandom_range(99)) >= gap_pct);
            start = (poke_start && cyc == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (cyc == 0) chk({name, " running_after_start"}, running, 1);
            if (a_prev || a_acc >= K) chk({name, " act_ready_blocked"}, a_rdy, 0);
            if (w_prev || w_acc >= K) chk({name, " wgt_ready_blocked"}, w_rdy, 0);
            a_prev = av && a_rdy;
            w_prev = wv && w_rdy;
            if (a_prev) a_acc++;
            if (w_prev) w_acc++;
            if (ov) begin
                pulses++;
                got = od;
                pulse_cyc = cyc;
                chk({name, " running_during_out"}, running, 1);
            end
            if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) begin
                chk({name, " running_dropped"}, running, 0);
                chk({name, " data_held"}, od, exp);
            end
            if (pulse_cyc >= 0 && cyc >= pulse_cyc + 3) done = 1'b1;
            if (do_abort && a_acc >= 3 && w_acc >= 3) begin
                arst_n = 1'b0;
                #1;
                chk({name, " rst_act_ready"}, a_rdy, 0);
                chk({name, " rst_wgt_ready"}, w_rdy, 0);
                chk({name, " rst_out_valid"}, ov, 0);
                chk({name, " rst_running"}, running, 0);
                chk({name, " rst_out_data"}, od, 0);
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
                if (cyc >= 300) done = 1'b1;
            end
        end
        av = 1'b0;
        wv = 1'b0;
        start = 1'b0;
        if (do_abort) begin
            chk({name, " no_pulse"}, pulses, 0);
            repeat (2) @(posedge clk);
            #1 arst_n = 1'b1;
        end else begin
            chk({name, " pulse_count"}, pulses, 1);
            chk({name, " result"}, got, exp);
            chk({name, " act_transfers"}, a_acc, K);
            chk({name, " wgt_transfers"}, w_acc, K);
        end
    endtask

    task automatic fill_const(input logic [BW-1:0] a, input logic [BW-1:0] w);
        for (int k = 0; k < 6; k++) begin
            job_act[k] = (k < K) ? a : {$urandom, $urandom};
            job_wgt[k] = (k < K) ? w : {$urandom, $urandom};
        end
    endtask

    initial begin
        vecs[0] = '{"basic",  64'h0101010101010101, 64'h0202020202020202, 64'h0808080808080808};
        vecs[1] = '{"signed", 64'hFFFFFFFFFFFFFFFF, 64'h0303030303030303, 64'hF4F4F4F4F4F4F4F4};
        vecs[2] = '{"sat",    64'h808080807F7F7F7F, 64'h7F7F7F7F7F7F7F7F, 64'h808080807F7F7F7F};
        vecs[3] = '{"ramp",   64'h0102030405060708, 64'h0101010101010101, 64'h04080C1014181C20};

        repeat (2) @(posedge clk);
        #1;
        chk("reset act_ready", a_rdy, 0);
        chk("reset wgt_ready", w_rdy, 0);
        chk("reset out_valid", ov, 0);
        chk("reset running", running, 0);
        chk("reset out_data", od, 0);
        arst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            fill_const(vecs[i].act, vecs[i].wgt);
            run_job(vecs[i].name, 0, 0, 1'b0, 1'b0, vecs[i].exp);
        end

        fill_const(64'h0101010101010101, 64'h0202020202020202);
        run_job("skew", 30, 3, 1'b1, 1'b0, 64'h0808080808080808);

        fill_const(64'h0101010101010101, 64'h0202020202020202);
        run_job("abort", 0, 0, 1'b0, 1'b1, 64'h0);
        run_job("after_abort", 0, 0, 1'b0, 1'b0, 64'h0808080808080808);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 6; k++) begin
                job_act[k] = {$urandom, $urandom};
                job_wgt[k] = {$urandom, $urandom};
            end
            run_job("random", 25, int'($urandom_range(4)), 1'b0, 1'b0, ref_result());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
